// File: rtl/mips_pkg.sv
// Shared pipeline constants and hazard-controller state encodings.
package mips_pkg;

    localparam int REG_IDX_W = 5;

    typedef enum logic [1:0] {
        HZ_RUN     = 2'd0,
        HZ_MULDIV  = 2'd1,
        HZ_LOCKOUT = 2'd2
    } hazardState_t;

    // A load in EX whose destination is read by the instruction in ID; $zero never conflicts.
    function automatic logic isLoadUse(
        input logic                 exMemRead,
        input logic [REG_IDX_W-1:0] exRt,
        input logic [REG_IDX_W-1:0] idRs,
        input logic [REG_IDX_W-1:0] idRt,
        input logic                 idUsesRt
    );
        return exMemRead && (exRt != '0) &&
               ((exRt == idRs) || (idUsesRt && (exRt == idRt)));
    endfunction

endpackage

// File: rtl/sat_counter16.sv
// 16-bit event counter that sticks at all-ones instead of wrapping.
module sat_counter16 (
    input  logic        clk,
    input  logic        clrN,
    input  logic        en,
    output logic [15:0] count
);

    always_ff @(posedge clk or negedge clrN) begin
        if (!clrN) begin
            count <= '0;
        end else if (en && (count != 16'hFFFF)) begin
            count <= count + 16'd1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline hazard controller: load-use stall, taken-branch flush, optional mul/div hold.
// Optional mul/div occupancy support is built when HAZARD_MULDIV_EN is defined.
//
// state   | meaning
// RUN     | normal issue; load-use hazards stall PC and IF/ID for one cycle
// MULDIV  | multi-cycle mul/div occupying EX; front end frozen, EX/MEM fed bubbles
// LOCKOUT | cycle after a taken branch; hazard operands belong to flushed work
module pipeline_hazard_ctrl
    import mips_pkg::*;
#(
    parameter int unsigned MULDIV_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [REG_IDX_W-1:0] id_rs,
    input  logic [REG_IDX_W-1:0] id_rt,
    input  logic                 id_uses_rt,
    input  logic                 ex_memread,
    input  logic [REG_IDX_W-1:0] ex_rt,
    input  logic                 mem_branch_taken,
`ifdef HAZARD_MULDIV_EN
    input  logic                 ex_muldiv_start,
`endif
    output logic                 pc_write,
    output logic                 ifid_write,
    output logic                 idex_write,
    output logic                 ifid_flush,
    output logic                 idex_bubble,
    output logic                 exmem_flush,
    output logic [1:0]           state,
    output logic [15:0]          stall_cnt,
    output logic [15:0]          flush_cnt
);

    if ((MULDIV_CYCLES < 2) || (MULDIV_CYCLES > 15)) begin : gBadMuldivCycles
        $error("MULDIV_CYCLES must lie in 2..15");
    end

    hazardState_t stateQ;
    logic         loadUse;

`ifdef HAZARD_MULDIV_EN
    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);
    logic [3:0] muldivCnt;
`endif

    assign loadUse = isLoadUse(ex_memread, ex_rt, id_rs, id_rt, id_uses_rt) &&
                     (stateQ == HZ_RUN);
    assign state   = stateQ;

    // Outputs are forced to their idle values while reset is held.
    always_comb begin
        pc_write    = 1'b1;
        ifid_write  = 1'b1;
        idex_write  = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        if (rst) begin
            if (mem_branch_taken) begin
                ifid_flush  = 1'b1;
                idex_bubble = 1'b1;
                exmem_flush = 1'b1;
            end else if (stateQ == HZ_MULDIV) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_write  = 1'b0;
                exmem_flush = 1'b1;
            end else if (loadUse) begin
                pc_write    = 1'b0;
                ifid_write  = 1'b0;
                idex_bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stateQ <= HZ_RUN;
`ifdef HAZARD_MULDIV_EN
            muldivCnt <= '0;
`endif
        end else if (mem_branch_taken) begin
            stateQ <= HZ_LOCKOUT;
`ifdef HAZARD_MULDIV_EN
            muldivCnt <= '0;
`endif
        end else begin
            case (stateQ)
                HZ_RUN: begin
`ifdef HAZARD_MULDIV_EN
                    if (ex_muldiv_start) begin
                        stateQ    <= HZ_MULDIV;
                        muldivCnt <= MULDIV_LOAD;
                    end
`endif
                end
`ifdef HAZARD_MULDIV_EN
                HZ_MULDIV: begin
                    if (muldivCnt == 4'd0) begin
                        stateQ <= HZ_RUN;
                    end else begin
                        muldivCnt <= muldivCnt - 4'd1;
                    end
                end
`endif
                HZ_LOCKOUT: stateQ <= HZ_RUN;
                default:    stateQ <= HZ_RUN;
            endcase
        end
    end

    sat_counter16 uStallCnt (
        .clk   (clk),
        .clrN  (rst),
        .en    (!pc_write),
        .count (stall_cnt)
    );

    sat_counter16 uFlushCnt (
        .clk   (clk),
        .clrN  (rst),
        .en    (ifid_flush),
        .count (flush_cnt)
    );

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter: MULDIV_CYCLES, default 4, EX-stage occupancy of a multiply/divide in cycles (legal range 2..15).
REQ-002 clk  in  1  single clock, rising edge.
REQ-003 rst  in  1  asynchronous, active-low reset.
REQ-004 id_rs, id_rt  in  5 each  source register fields of the instruction in ID (from the IF/ID register).
REQ-005 id_uses_rt  in  1  instruction in ID reads rt as a source.
REQ-006 ex_memread, ex_rt  in  1, 5  MemRead and Rt of the instruction in EX (ID/EX register).
REQ-007 mem_branch_taken  in  1  branch in MEM resolved taken (Branch AND Zero).
REQ-008 ex_muldiv_start  in  1  mul/div instruction entering EX this cycle (present only with the macro).
REQ-009 pc_write, ifid_write, idex_write  out  1 each  stage register write enables.
REQ-010 ifid_flush, idex_bubble, exmem_flush  out  1 each  zero the instruction/control fields of that pipeline register.
REQ-011 state  out  2  current FSM state (RUN=0, MULDIV=1, LOCKOUT=2).
REQ-012 stall_cnt, flush_cnt  out  16 each  saturating performance counters.

Function
REQ-013 The enables and flush outputs SHALL be combinational from inputs and registered state; all counters and state SHALL be registered.
REQ-014 Load-use hazard = ex_memread AND ex_rt!=0 AND (ex_rt==id_rs OR (id_uses_rt AND ex_rt==id_rt)).
REQ-015 On a load-use hazard in RUN: pc_write=0, ifid_write=0, idex_bubble=1, for exactly one cycle (the bubble clears ex_memread next cycle).
REQ-016 mem_branch_taken SHALL assert ifid_flush, idex_bubble and exmem_flush in the same cycle, with pc_write=1; it has priority over the load-use stall.
REQ-017 After a taken branch, FSM SHALL enter LOCKOUT for one cycle, suppressing load-use detection (its operands belong to flushed instructions), then return to RUN.
REQ-018 In RUN with no event: all write enables=1, all flush/bubble outputs=0.
REQ-019 stall_cnt SHALL increment on every cycle with pc_write=0; flush_cnt SHALL increment on every taken-branch cycle; both SHALL saturate at 16'hFFFF and never wrap.
REQ-020 Register 0 SHALL never produce a hazard.

Reset
REQ-021 While rst=0: state=RUN, both counters=0, MULDIV counter=0; outputs take their RUN/no-event values.
REQ-022 Reset asserted mid-stall or mid-MULDIV SHALL abort the sequence immediately; the first cycle after deassertion behaves as RUN.

Configuration
REQ-023 Macro HAZARD_MULDIV_EN: when defined, ex_muldiv_start exists and the MULDIV state is implemented.
REQ-024 With the macro: ex_muldiv_start in RUN loads a 4-bit counter with MULDIV_CYCLES-1 and enters MULDIV.
REQ-025 In MULDIV: pc_write=0, ifid_write=0, idex_write=0, exmem_flush=1; the counter decrements each cycle; at 0, return to RUN on the next edge; load-use detection is suppressed.
REQ-026 mem_branch_taken during MULDIV SHALL still flush and SHALL abort MULDIV into LOCKOUT.
REQ-027 Without the macro: no port, no counter, state never equals 1.

Structure
REQ-028 Shared package mips_pkg holds the REG_IDX_W=5 constant and the hazard state enum/encodings.
REQ-029 Sub-module sat_counter16 (enable, async active-low clear, saturating) SHALL be instantiated twice, once per counter.

Verification
REQ-030 lw $5 in EX (ex_memread=1, ex_rt=5), ID reads rs=5 -> one cycle of pc_write=0, ifid_write=0, idex_bubble=1; stall_cnt 0->1.
REQ-031 ex_rt=0 with ex_memread=1, id_rs=0 -> no stall, stall_cnt stays 0.
REQ-032 Load-use hazard and mem_branch_taken in the same cycle -> flush triple asserted, pc_write=1, state=LOCKOUT next cycle, flush_cnt=1, stall_cnt=0.
REQ-033 Macro defined, MULDIV_CYCLES=4, ex_muldiv_start pulse -> pc_write=0 for exactly 4 cycles, state 1 for 4 cycles, then RUN; stall_cnt=4.
REQ-034 Preload stall_cnt to 16'hFFFE via continuous stalls, then stall 3 more cycles -> stall_cnt holds 16'hFFFF.
REQ-035 rst pulsed low in the 2nd MULDIV cycle -> state=0 and counters=0 asynchronously; after release, pc_write=1.
